// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C pass-through bit sequencer: state encodings,
// byte geometry and the per-bit classification helper.
package i2c_passthru_pkg;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_LAUNCH_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC   = 2'd2;
    localparam logic [1:0] ST_EVAL_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_LAUNCH = ST_LAUNCH_ENC,
        ST_WAIT   = ST_WAIT_ENC,
        ST_EVAL   = ST_EVAL_ENC
    } state_e;

    localparam int         BYTE_W    = 8;
    localparam int         BIT_CNT_W = 4;
    localparam logic [3:0] ACK_BIT   = 4'd8;

    typedef enum logic [1:0] {
        BIT_DATA   = 2'd0,
        BIT_RSTART = 2'd1,
        BIT_STOP   = 2'd2
    } bit_kind_e;

    // SDA moving while SCL is high: falling edge is a repeated START, rising is STOP.
    function automatic bit_kind_e classify_bit(input logic mid, input logic init,
                                               input logic fin);
        if (mid && init && !fin) begin
            return BIT_RSTART;
        end else if (mid && !init && fin) begin
            return BIT_STOP;
        end
        return BIT_DATA;
    endfunction

endpackage

// File: rtl/i2c_passthru_bitseq_timeout.sv
// Per-bit watchdog: counts i_f_ref rising edges while enabled, cleared at each bit launch.
module i2c_passthru_bitseq_timeout #(
    parameter int TIMEOUT_F_REF = 255,
    parameter int WIDTH_TIMEOUT = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_f_ref,
    input  logic i_clear,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [WIDTH_TIMEOUT-1:0] LIMIT = WIDTH_TIMEOUT'(TIMEOUT_F_REF);

    logic                     f_ref_q, f_ref_d;
    logic [WIDTH_TIMEOUT-1:0] cnt_q, cnt_d;

    always_comb begin
        f_ref_d = i_f_ref;
        cnt_d   = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en && i_f_ref && !f_ref_q && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        o_timeout = i_en && (cnt_q == LIMIT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            f_ref_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            f_ref_q <= f_ref_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_passthru_bitseq.sv
// I2C pass-through bit sequencer: launches one bit at a time, tracks byte/ack position
// and bus direction. Optional per-bit timeout enabled by I2C_PASSTHRU_BITSEQ_TIMEOUT_EN.
module i2c_passthru_bitseq
    import i2c_passthru_pkg::*;
#(
    parameter int TIMEOUT_F_REF = 255,
    parameter int WIDTH_TIMEOUT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_f_ref,
    input  logic                 i_go,
    input  logic                 i_rx_done,
    input  logic                 i_tx_done,
    input  logic                 i_rx_sda_init,
    input  logic                 i_rx_sda_final,
    input  logic                 i_rx_sda_mid_change,
    input  logic                 i_violation,
    output logic                 o_start_rx,
    output logic                 o_start_tx,
    output logic                 o_rx_frm_slv,
    output logic [BIT_CNT_W-1:0] o_bit_cnt,
    output logic [BYTE_W-1:0]    o_byte,
    output logic                 o_byte_valid,
    output logic                 o_rw,
    output logic                 o_nack,
    output logic                 o_rstart,
    output logic                 o_stop,
    output logic                 o_abort,
    output logic                 o_busy
);

    state_e                 state_q, state_d;
    logic                   rx_seen_q, rx_seen_d;
    logic                   tx_seen_q, tx_seen_d;
    logic                   init_q, init_d;
    logic                   final_q, final_d;
    logic                   mid_q, mid_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0]      shift_q, shift_d;
    logic [BYTE_W-1:0]      byte_q, byte_d;
    logic                   rw_q, rw_d;
    logic                   addr_phase_q, addr_phase_d;
    logic                   nacked_q, nacked_d;

    logic                   timeout;
    logic                   abort_now;
    logic                   is_ack;
    logic [BYTE_W-1:0]      new_byte;
    bit_kind_e              kind;

`ifdef I2C_PASSTHRU_BITSEQ_TIMEOUT_EN
    i2c_passthru_bitseq_timeout #(
        .TIMEOUT_F_REF (TIMEOUT_F_REF),
        .WIDTH_TIMEOUT (WIDTH_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_f_ref   (i_f_ref),
        .i_clear   (state_q == ST_LAUNCH),
        .i_en      (state_q == ST_WAIT),
        .o_timeout (timeout)
    );
`else
    logic unused_f_ref;
    assign timeout      = 1'b0;
    assign unused_f_ref = i_f_ref ^ (TIMEOUT_F_REF == 0) ^ (WIDTH_TIMEOUT == 0);
`endif

    assign new_byte  = {shift_q, final_q};
    assign kind      = classify_bit(mid_q, init_q, final_q);
    assign is_ack    = (bit_cnt_q == ACK_BIT);
    assign abort_now = ((state_q == ST_WAIT) || (state_q == ST_EVAL)) &&
                       (i_violation || ((state_q == ST_WAIT) && timeout));

    always_comb begin
        state_d      = state_q;
        rx_seen_d    = rx_seen_q;
        tx_seen_d    = tx_seen_q;
        init_d       = init_q;
        final_d      = final_q;
        mid_d        = mid_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        rw_d         = rw_q;
        addr_phase_d = addr_phase_q;
        nacked_d     = nacked_q;
        o_start_rx   = 1'b0;
        o_start_tx   = 1'b0;
        o_byte_valid = 1'b0;
        o_nack       = 1'b0;
        o_rstart     = 1'b0;
        o_stop       = 1'b0;
        o_abort      = abort_now;

        if (abort_now) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            addr_phase_d = 1'b1;
            nacked_d     = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_go && !i_violation) begin
                        state_d = ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    o_start_rx = 1'b1;
                    o_start_tx = 1'b1;
                    rx_seen_d  = 1'b0;
                    tx_seen_d  = 1'b0;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    rx_seen_d = rx_seen_q | i_rx_done;
                    tx_seen_d = tx_seen_q | i_tx_done;
                    // Receiver results are captured when its done first shows, so they
                    // need not be held until the transmitter finishes.
                    if (i_rx_done && !rx_seen_q) begin
                        init_d  = i_rx_sda_init;
                        final_d = i_rx_sda_final;
                        mid_d   = i_rx_sda_mid_change;
                    end
                    if (rx_seen_d && tx_seen_d) begin
                        state_d = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    unique case (kind)
                        BIT_RSTART: begin
                            o_rstart     = 1'b1;
                            bit_cnt_d    = '0;
                            addr_phase_d = 1'b1;
                            nacked_d     = 1'b0;
                            state_d      = ST_LAUNCH;
                        end
                        BIT_STOP: begin
                            o_stop       = 1'b1;
                            bit_cnt_d    = '0;
                            addr_phase_d = 1'b1;
                            nacked_d     = 1'b0;
                            state_d      = ST_IDLE;
                        end
                        default: begin
                            if (is_ack) begin
                                bit_cnt_d    = '0;
                                addr_phase_d = 1'b0;
                                if (final_q) begin
                                    o_nack   = 1'b1;
                                    nacked_d = 1'b1;
                                end
                            end else begin
                                shift_d   = new_byte[BYTE_W-2:0];
                                bit_cnt_d = bit_cnt_q + 4'd1;
                                if (bit_cnt_q == ACK_BIT - 4'd1) begin
                                    o_byte_valid = 1'b1;
                                    byte_d       = new_byte;
                                    if (addr_phase_q) begin
                                        rw_d = final_q;
                                    end
                                end
                            end
                            state_d = ST_LAUNCH;
                        end
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Slave drives the address ack, write-phase acks and read-phase data, unless a NACK ended the exchange.
    always_comb begin
        o_rx_frm_slv = 1'b0;
        if ((state_q != ST_IDLE) && !nacked_q) begin
            if (addr_phase_q || !rw_q) begin
                o_rx_frm_slv = is_ack;
            end else begin
                o_rx_frm_slv = !is_ack;
            end
        end
    end

    assign o_bit_cnt = bit_cnt_q;
    assign o_byte    = o_byte_valid ? new_byte : byte_q;
    assign o_rw      = rw_q;
    assign o_busy    = (state_q != ST_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            rx_seen_q    <= 1'b0;
            tx_seen_q    <= 1'b0;
            init_q       <= 1'b0;
            final_q      <= 1'b0;
            mid_q        <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            rw_q         <= 1'b0;
            addr_phase_q <= 1'b1;
            nacked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_seen_q    <= rx_seen_d;
            tx_seen_q    <= tx_seen_d;
            init_q       <= init_d;
            final_q      <= final_d;
            mid_q        <= mid_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            rw_q         <= rw_d;
            addr_phase_q <= addr_phase_d;
            nacked_q     <= nacked_d;
        end
    end

endmodule

// File: tb/tb_i2c_passthru_bitseq.sv
// Directed bench for i2c_passthru_bitseq: per-bit vector table plus hand-written
// abort, reset and timeout sequences (timeout variant under I2C_PASSTHRU_BITSEQ_TIMEOUT_EN).
module tb_i2c_passthru_bitseq;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_f_ref = 1'b0;
    logic       i_go = 1'b0;
    logic       i_rx_done = 1'b0;
    logic       i_tx_done = 1'b0;
    logic       i_rx_sda_init = 1'b0;
    logic       i_rx_sda_final = 1'b0;
    logic       i_rx_sda_mid_change = 1'b0;
    logic       i_violation = 1'b0;
    logic       o_start_rx, o_start_tx, o_rx_frm_slv;
    logic [3:0] o_bit_cnt;
    logic [7:0] o_byte;
    logic       o_byte_valid, o_rw, o_nack, o_rstart, o_stop, o_abort, o_busy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 i_clk = ~i_clk;

    i2c_passthru_bitseq #(
        .TIMEOUT_F_REF (20),
        .WIDTH_TIMEOUT (8)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_f_ref             (i_f_ref),
        .i_go                (i_go),
        .i_rx_done           (i_rx_done),
        .i_tx_done           (i_tx_done),
        .i_rx_sda_init       (i_rx_sda_init),
        .i_rx_sda_final      (i_rx_sda_final),
        .i_rx_sda_mid_change (i_rx_sda_mid_change),
        .i_violation         (i_violation),
        .o_start_rx          (o_start_rx),
        .o_start_tx          (o_start_tx),
        .o_rx_frm_slv        (o_rx_frm_slv),
        .o_bit_cnt           (o_bit_cnt),
        .o_byte              (o_byte),
        .o_byte_valid        (o_byte_valid),
        .o_rw                (o_rw),
        .o_nack              (o_nack),
        .o_rstart            (o_rstart),
        .o_stop              (o_stop),
        .o_abort             (o_abort),
        .o_busy              (o_busy)
    );

    typedef struct {
        bit         go;
        int         rxd;
        int         txd;
        bit         init;
        bit         fin;
        bit         mid;
        logic [3:0] cnt;
        bit         dir;
        bit         valid;
        logic [7:0] byt;
        bit         nack;
        bit         stop;
        bit         rstart;
        bit         rw;
    } bit_rec_t;

    bit_rec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_bit(input bit go, input int rxd, input int txd, input bit init,
                           input bit fin, input bit mid, input logic [3:0] cnt, input bit dir,
                           input bit valid, input logic [7:0] byt, input bit nack,
                           input bit stop, input bit rstart, input bit rw);
        bit_rec_t r;
        r.go = go; r.rxd = rxd; r.txd = txd; r.init = init; r.fin = fin; r.mid = mid;
        r.cnt = cnt; r.dir = dir; r.valid = valid; r.byt = byt; r.nack = nack;
        r.stop = stop; r.rstart = rstart; r.rw = rw;
        tbl.push_back(r);
    endtask

    task automatic add_byte(input bit go, input logic [7:0] val, input bit dir, input bit rw);
        for (int b = 0; b < 8; b++) begin
            add_bit(go && (b == 0), 1, 1, 1'b0, val[7-b], 1'b0, 4'(b), dir,
                    b == 7, val, 1'b0, 1'b0, 1'b0, rw);
        end
    endtask

    task automatic cyc(input bit rx, input bit tx);
        @(posedge i_clk);
        #1;
        i_rx_done = rx;
        i_tx_done = tx;
        #3;
    endtask

    task automatic go_pulse();
        @(posedge i_clk);
        #1 i_go = 1'b1;
        #3;
        @(posedge i_clk);
        #1 i_go = 1'b0;
        #3;
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({o_start_rx, o_start_tx, o_rx_frm_slv, o_bit_cnt, o_byte, o_byte_valid,
                    o_rw, o_nack, o_rstart, o_stop, o_abort, o_busy});
    endfunction

    // Entered while the DUT shows the LAUNCH cycle; leaves at the cycle after EVAL.
    task automatic run_bit(input int idx, input bit_rec_t r);
        int  d;
        bit  quiet;
        logic [7:0] byte_seen;
        i_rx_sda_init       = r.init;
        i_rx_sda_final      = r.fin;
        i_rx_sda_mid_change = r.mid;
        check($sformatf("start[%0d]", idx), 32'({o_start_rx, o_start_tx, o_busy}), 32'h7);
        check($sformatf("launch[%0d]", idx), 32'({o_rx_frm_slv, o_bit_cnt}), 32'({r.dir, r.cnt}));
        d = (r.rxd > r.txd) ? r.rxd : r.txd;
        quiet = 1'b1;
        for (int k = 1; k <= d; k++) begin
            cyc(k == r.rxd, k == r.txd);
            if (o_start_rx || o_start_tx || o_byte_valid || o_stop || o_rstart || o_nack ||
                o_abort || !o_busy || (o_rx_frm_slv != r.dir)) quiet = 1'b0;
        end
        check($sformatf("wait[%0d]", idx), 32'(quiet), 32'h1);
        cyc(1'b0, 1'b0);
        byte_seen = r.valid ? o_byte : 8'h00;
        check($sformatf("eval[%0d]", idx),
              32'({o_byte_valid, byte_seen, o_nack, o_stop, o_rstart, o_abort, o_rx_frm_slv,
                   o_rw, o_start_rx}),
              32'({r.valid, (r.valid ? r.byt : 8'h00), r.nack, r.stop, r.rstart, 1'b0, r.dir,
                   r.rw, 1'b0}));
        cyc(1'b0, 1'b0);
        if (r.stop) begin
            check($sformatf("stop_idle[%0d]", idx), 32'({o_busy, o_start_rx, o_start_tx}), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rises;
        int rise_at_abort;
        int aborts;
        bit seen;

        // Reset state
        #1 i_rst = 1'b1;
        #2;
        check("reset_async", out_vec(), 32'h0);
        repeat (3) @(posedge i_clk);
        #4;
        check("reset_held", out_vec(), 32'h0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        #3;

        // Go ignored while violation is flagged in IDLE
        @(posedge i_clk);
        #1 i_go = 1'b1; i_violation = 1'b1;
        #3;
        @(posedge i_clk);
        #1 i_go = 1'b0; i_violation = 1'b0;
        #3;
        check("go_blocked", 32'({o_busy, o_start_rx}), 32'h0);

        // Write transfer: address A0, data 5C with NACK, STOP at bit 3
        add_byte(1'b1, 8'hA0, 1'b0, 1'b0);
        tbl[0].txd = 4;
        tbl[1].rxd = 2; tbl[1].txd = 2;
        tbl[2].rxd = 3;
        add_bit(0, 1, 1, 0, 0, 0, 4'd8, 1, 0, 8'h00, 0, 0, 0, 0);
        add_byte(1'b0, 8'h5C, 1'b0, 1'b0);
        add_bit(0, 1, 1, 0, 1, 0, 4'd8, 1, 0, 8'h00, 1, 0, 0, 0);
        add_bit(0, 1, 1, 0, 1, 0, 4'd0, 0, 0, 8'h00, 0, 0, 0, 0);
        add_bit(0, 1, 1, 0, 0, 0, 4'd1, 0, 0, 8'h00, 0, 0, 0, 0);
        add_bit(0, 1, 1, 0, 1, 0, 4'd2, 0, 0, 8'h00, 0, 0, 0, 0);
        add_bit(0, 1, 1, 0, 1, 1, 4'd3, 0, 0, 8'h00, 0, 1, 0, 0);
        // Read transfer: address A1, data 3C and 81, repeated START on the last ack
        add_byte(1'b1, 8'hA1, 1'b0, 1'b0);
        add_bit(0, 1, 1, 0, 0, 0, 4'd8, 1, 0, 8'h00, 0, 0, 0, 1);
        add_byte(1'b0, 8'h3C, 1'b1, 1'b1);
        add_bit(0, 1, 1, 0, 0, 0, 4'd8, 0, 0, 8'h00, 0, 0, 0, 1);
        add_byte(1'b0, 8'h81, 1'b1, 1'b1);
        add_bit(0, 1, 1, 1, 0, 1, 4'd8, 0, 0, 8'h00, 0, 0, 1, 1);
        add_bit(0, 1, 1, 0, 1, 0, 4'd0, 0, 0, 8'h00, 0, 0, 0, 1);
        add_bit(0, 1, 1, 0, 1, 1, 4'd1, 0, 0, 8'h00, 0, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].go) go_pulse();
            run_bit(i, tbl[i]);
        end

        // Violation together with both dones on bit 7: abort, no byte
        tbl.delete();
        for (int b = 0; b < 7; b++) begin
            add_bit(b == 0, 1, 1, 0, 1, 0, 4'(b), 0, 0, 8'h00, 0, 0, 0, 1);
        end
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].go) go_pulse();
            run_bit(100 + i, tbl[i]);
        end
        check("viol_launch", 32'({o_start_rx, o_bit_cnt}), 32'h17);
        @(posedge i_clk);
        #1 i_violation = 1'b1; i_rx_done = 1'b1; i_tx_done = 1'b1;
        #3;
        check("viol_abort", 32'({o_abort, o_byte_valid, o_busy}), 32'h5);
        @(posedge i_clk);
        #1 i_violation = 1'b0; i_rx_done = 1'b0; i_tx_done = 1'b0;
        #3;
        check("viol_idle", 32'({o_abort, o_byte_valid, o_busy, o_start_rx}), 32'h0);
        cyc(1'b0, 1'b0);
        check("viol_stay", 32'({o_busy, o_start_rx, o_byte}), 32'h081);

        // Timeout on a stuck bit
        go_pulse();
        rises = 0;
        rise_at_abort = -1;
        aborts = 0;
`ifdef I2C_PASSTHRU_BITSEQ_TIMEOUT_EN
        seen = 1'b0;
        for (int j = 0; j < 120 && !seen; j++) begin
            @(posedge i_clk);
            #1 i_f_ref = (j % 2 == 0);
            if (i_f_ref) rises++;
            #3;
            if (o_abort) begin
                seen = 1'b1;
                rise_at_abort = rises;
            end
        end
        i_f_ref = 1'b0;
        check("timeout_abort", 32'(seen), 32'h1);
        check("timeout_edges", 32'(rise_at_abort), 32'd20);
        cyc(1'b0, 1'b0);
        check("timeout_idle", 32'({o_busy, o_abort}), 32'h0);
        go_pulse();
        cyc(1'b0, 1'b0);
`else
        for (int j = 0; j < 400; j++) begin
            @(posedge i_clk);
            #1 i_f_ref = (j % 2 == 0);
            if (i_f_ref) rises++;
            #3;
            if (o_abort) aborts++;
        end
        i_f_ref = 1'b0;
        check("no_timeout_abort", 32'(aborts), 32'h0);
        check("no_timeout_busy", 32'({o_busy, rises == 200}), 32'h3);
`endif

        // Asynchronous reset while waiting for dones
        check("pre_reset_busy", 32'(o_busy), 32'h1);
        #1 i_rst = 1'b1;
        #1;
        check("reset_mid_bit", out_vec(), 32'h0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        #3;
        seen = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc(1'b0, 1'b0);
            if (o_busy || o_start_rx || o_start_tx) seen = 1'b1;
        end
        check("reset_waits_go", 32'(seen), 32'h0);
        go_pulse();
        check("restart_after_reset", 32'({o_start_rx, o_start_tx, o_bit_cnt, o_rx_frm_slv}), 32'h60);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
